// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: opcode encodings, the
// chain-select bit position, and the width-independent 8-op result function.
package logic_unit_pkg;

  // Opcode encodings carried in in_op[2:0].
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NEG  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  // in_op bit that substitutes the accumulator for operand A.
  localparam int CHAIN_BIT = 3;

  // Widest operand the shared function handles. Callers zero-extend their
  // operands to this width and keep only their low WIDTH bits of the result,
  // which is exact because every op is bitwise except negation, and negation
  // is supplied already computed at the caller's width.
  localparam int LU_MAX_W = 128;
  typedef logic [LU_MAX_W-1:0] lu_word_t;

  function automatic lu_word_t lu_compute(input logic [2:0] op,
                                          input lu_word_t   a,
                                          input lu_word_t   b,
                                          input lu_word_t   neg_a);
    lu_word_t r;
    case (op)
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_NOR:  r = ~(a | b);
      OP_NEG:  r = neg_a;
      OP_XNOR: r = ~(a ^ b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lu_negate.sv
// Combinational two's complement at WIDTH bits: (~a + 1) mod 2^WIDTH.
// Kept as its own block so the future adder unit can reuse it.
module lu_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] neg_o
);

  // Wraps naturally: 0 -> 0 and the most negative value maps to itself.
  assign neg_o = ~a_i + WIDTH'(1);

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined 8-op logic unit with a valid/ready handshake, one registered
// output stage, a chaining accumulator, result flags and a saturating
// completed-op counter. Sits between operand fetch and the writeback bus.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,   // 2 <= WIDTH <= LU_MAX_W
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_parity,
  output logic             out_msb,
  output logic [WIDTH-1:0] acc_value,
  output logic [CNT_W-1:0] op_count
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_zero_q;
  logic             out_parity_q;
  logic             out_msb_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] neg_a;
  logic [WIDTH-1:0] result_d;

  // Ready is combinational from out_ready so a stalled result and a new
  // request can swap on the same edge: full throughput without a skid buffer.
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Chained ops read the accumulator as it stood before this edge.
  assign op_a = in_op[CHAIN_BIT] ? acc_q : in_a;

  lu_negate #(.WIDTH(WIDTH)) u_negate (
    .a_i   (op_a),
    .neg_o (neg_a)
  );

  // Select the op result and the saturating counter's next value.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path; missing one
    // would infer a latch.
    result_d = WIDTH'(lu_compute(in_op[2:0], LU_MAX_W'(op_a), LU_MAX_W'(in_b),
                                 LU_MAX_W'(neg_a)));
    cnt_d    = cnt_q;
    if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output stage: load result and its flags on accept, drain on out_ready.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_zero_q   <= 1'b0;
      out_parity_q <= 1'b0;
      out_msb_q    <= 1'b0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= result_d;
      out_zero_q   <= (result_d == '0);
      out_parity_q <= ^result_d;
      out_msb_q    <= result_d[WIDTH-1];
    end else if (out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  // Accumulator: captures each accepted result; a clear on the same edge wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= result_d;
    end
  end

  // Completed-op counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_zero   = out_zero_q;
  assign out_parity = out_parity_q;
  assign out_msb    = out_msb_q;
  assign acc_value  = acc_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe at WIDTH=16, CNT_W=2: directed
// scenarios with fixed expected values, then randomized traffic checked
// against a behavioural model of the handshake, accumulator and counter.
module tb_logic_unit_pipe;

  localparam int W = 16;
  localparam int C = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_zero;
  logic         out_parity;
  logic         out_msb;
  logic [W-1:0] acc_value;
  logic [C-1:0] op_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  logic         m_zero  = 1'b0;
  logic         m_par   = 1'b0;
  logic         m_msb   = 1'b0;
  logic [W-1:0] m_acc   = '0;
  int           m_cnt   = 0;

  logic_unit_pipe #(.WIDTH(W), .CNT_W(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .out_msb    (out_msb),
    .acc_value  (acc_value),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  // Operation table written arithmetically from the opcode definitions.
  function automatic logic [W-1:0] ref_op(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    int ai;
    ai = int'(a);
    case (op)
      3'd0: return a & b;
      3'd1: return a ^ b;
      3'd2: return ~(a & b);
      3'd3: return a | b;
      3'd4: return W'((1 << W) - 1 - ai);
      3'd5: return ~(a | b);
      3'd6: return W'(((1 << W) - ai) % (1 << W));
      default: return ~(a ^ b);
    endcase
  endfunction

  // Advance the model with the current inputs, then clock the DUT and
  // settle 1 time unit past the edge.
  task automatic tick();
    logic         rdy;
    logic         acc_ev;
    logic [W-1:0] opa;
    logic [W-1:0] r;
    rdy    = !m_valid || out_ready;
    acc_ev = in_valid && rdy;
    opa    = in_op[3] ? m_acc : in_a;
    r      = ref_op(in_op[2:0], opa, in_b);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_zero = 1'b0; m_par = 1'b0; m_msb = 1'b0;
      m_acc = '0; m_cnt = 0;
    end else begin
      if (acc_ev) begin
        m_valid = 1'b1;
        m_data  = r;
        m_zero  = (r == 0);
        m_par   = ($countones(r) % 2) == 1;
        m_msb   = (r >= (1 << (W - 1)));
        if (m_cnt < (1 << C) - 1) m_cnt = m_cnt + 1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (acc_clr) m_acc = '0;
      else if (acc_ev) m_acc = r;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_a = '0; in_b = '0;
    acc_clr = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_data, out_zero, out_parity, out_msb} !== {1'b0, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h z=%b p=%b m=%b want all zero",
               out_valid, out_data, out_zero, out_parity, out_msb);
    end
    checks++;
    if (acc_value !== 16'h0 || op_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got acc=%h cnt=%0d want 0 0", acc_value, op_count);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    in_valid = 1'b1; in_a = 16'hC0DB; in_b = 16'h18BC; in_op = 4'b0000;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready0: got %b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0098) begin
      errors++; $display("FAIL b2b_and: got v=%b d=%h want 1 0098", out_valid, out_data);
    end
    in_op = 4'b0001;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready1: got %b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hD867) begin
      errors++; $display("FAIL b2b_xor: got v=%b d=%h want 1 d867", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_negate();
    logic [W-1:0] a_vec [3] = '{16'hC0DB, 16'h8000, 16'h0000};
    logic [W-1:0] d_vec [3] = '{16'h3F25, 16'h8000, 16'h0000};
    logic         m_vec [3] = '{1'b0, 1'b1, 1'b0};
    logic         z_vec [3] = '{1'b0, 1'b0, 1'b1};
    idle_inputs();
    in_valid = 1'b1; in_op = 4'b0110; in_b = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      in_a = a_vec[i];
      tick();
      checks++;
      if (out_data !== d_vec[i] || out_msb !== m_vec[i] || out_zero !== z_vec[i]) begin
        errors++;
        $display("FAIL negate_%0d: got d=%h msb=%b z=%b want d=%h msb=%b z=%b",
                 i, out_data, out_msb, out_zero, d_vec[i], m_vec[i], z_vec[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_chain();
    idle_inputs();
    in_valid = 1'b1; in_op = 4'b0000; in_a = 16'hC0DB; in_b = 16'h18BC;
    tick();
    checks++;
    if (acc_value !== 16'h0098) begin
      errors++; $display("FAIL chain_seed: got acc=%h want 0098", acc_value);
    end
    in_op = 4'b1011; in_a = 16'h1234; in_b = 16'h0F00;
    tick();
    checks++;
    if (out_data !== 16'h0F98 || acc_value !== 16'h0F98 || out_parity !== 1'b1) begin
      errors++;
      $display("FAIL chain_or: got d=%h acc=%h p=%b want 0f98 0f98 1",
               out_data, acc_value, out_parity);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    idle_inputs();
    in_valid = 1'b1; in_op = 4'b0001; in_a = 16'hA5A5; in_b = 16'h0FF0;
    tick();
    held = ref_op(3'd1, 16'hA5A5, 16'h0FF0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a = 16'h1111 * 16'(i + 1);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready_%0d: got %b want 0", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v=%b d=%h want 1 %h", i, out_valid, out_data, held);
      end
    end
    out_ready = 1'b1; in_op = 4'b0011; in_a = 16'h00F0; in_b = 16'h0F00;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0FF0) begin
      errors++; $display("FAIL bp_next: got v=%b d=%h want 1 0ff0", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_single_consume: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_acc_clr();
    idle_inputs();
    in_valid = 1'b1; in_op = 4'b0011; in_a = 16'h00FF; in_b = 16'h0000;
    tick();
    in_op = 4'b1100; acc_clr = 1'b1;
    tick();
    checks++;
    if (out_data !== 16'hFF00 || acc_value !== 16'h0000) begin
      errors++;
      $display("FAIL clr_with_chain: got d=%h acc=%h want ff00 0000", out_data, acc_value);
    end
    acc_clr = 1'b0; in_op = 4'b0011; in_a = 16'h1357;
    tick();
    in_valid = 1'b0; acc_clr = 1'b1;
    tick();
    checks++;
    if (acc_value !== 16'h0000 || out_data !== 16'h1357) begin
      errors++;
      $display("FAIL clr_only: got acc=%h d=%h want 0000 1357", acc_value, out_data);
    end
    acc_clr = 1'b0;
    tick();
  endtask

  task automatic test_counter_and_reset();
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b1; in_op = 4'b0001; in_b = 16'h00FF;
    for (int i = 0; i < 5; i++) begin
      in_a = W'(i * 16'h0101);
      tick();
      checks++;
      if (op_count !== C'(exp_cnt[i])) begin
        errors++; $display("FAIL count_%0d: got %0d want %0d", i, op_count, exp_cnt[i]);
      end
    end
    out_ready = 1'b0; in_a = 16'hFFFF; in_b = 16'h0001;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if ({out_valid, out_data, out_zero, out_parity, out_msb, acc_value, op_count} !== '0) begin
      errors++;
      $display("FAIL stall_reset: got v=%b d=%h z=%b p=%b m=%b acc=%h cnt=%0d want all zero",
               out_valid, out_data, out_zero, out_parity, out_msb, acc_value, op_count);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] corner [4] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h0001};
    logic         exp_ready;
    idle_inputs();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_op     = 4'($urandom);
      in_a      = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      in_b      = W'($urandom);
      acc_clr   = ($urandom_range(0, 9) == 0);
      exp_ready = !m_valid || out_ready;
      #1;
      checks++;
      if (in_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready_%0d: got %b want %b", i, in_ready, exp_ready);
      end
      tick();
      checks++;
      if ({out_valid, out_data, out_zero, out_parity, out_msb, acc_value, op_count} !==
          {m_valid, m_data, m_zero, m_par, m_msb, m_acc, C'(m_cnt)}) begin
        errors++;
        $display("FAIL rand_state_%0d: got v=%b d=%h z=%b p=%b m=%b acc=%h cnt=%0d want v=%b d=%h z=%b p=%b m=%b acc=%h cnt=%0d",
                 i, out_valid, out_data, out_zero, out_parity, out_msb, acc_value, op_count,
                 m_valid, m_data, m_zero, m_par, m_msb, m_acc, m_cnt);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    #2;
    test_reset();
    test_back_to_back();
    test_negate();
    test_chain();
    test_backpressure();
    test_acc_clr();
    test_counter_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
